// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WCNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  // Request captured from the MEM stage while the responder is idle.
  typedef struct packed {
    op_e               op;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Word index of a byte address relative to the region base (wrap-around subtraction).
  function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] base);
    return (addr - base) >> WORD_SHIFT;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with a synchronous write port and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] widx,
  input  logic [DATA_W-1:0]              wdata,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ridx,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Contents are never cleared; only the write strobe updates them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Read register holds its value until the next enabled read; cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[ridx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: wait-state FSM, address decode and error checks.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_read_en,
  input  logic              req_write_en,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              resp_ack,
  output logic              addr_err
);

  localparam int unsigned       IDX_W     = $clog2(DEPTH_WORDS);
  localparam bit                ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [WCNT_W-1:0] WCNT_INIT = ZERO_WAIT ? '0 : WCNT_W'(WAIT_CYCLES - 1);

  state_e            state;
  logic [WCNT_W-1:0] wcnt;
  req_t              lat;
  req_t              in_req;
  logic              req;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic              mem_re;
  logic [IDX_W-1:0]  mem_ridx;

  // Rejects misaligned or out-of-range byte addresses.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] widx;
    widx = word_index(addr, ADDR_BASE);
    return (addr[1:0] != 2'b00) || (widx >= ADDR_W'(DEPTH_WORDS));
  endfunction

  // Decode of the live request presented by the MEM stage.
  always_comb begin
    req          = req_read_en | req_write_en;
    in_req.op    = req_write_en ? OP_WR : OP_RD;
    in_req.err   = (req_read_en & req_write_en) | addr_bad(req_addr);
    in_req.addr  = req_addr;
    in_req.wdata = req_wdata;
  end

  // Pipeline freeze: from first sight of a request until the response cycle.
  always_comb begin
    stall = reset & (((state == IDLE) & req) | (state == BUSY));
  end

  // Storage read fires on the edge that enters RESP so data is visible during RESP.
  always_comb begin
    mem_re   = 1'b0;
    mem_ridx = IDX_W'(word_index(lat.addr, ADDR_BASE));
    if (ZERO_WAIT && (state == IDLE) && req) begin
      mem_re   = ~in_req.err & (in_req.op == OP_RD);
      mem_ridx = IDX_W'(word_index(req_addr, ADDR_BASE));
    end else if ((state == BUSY) && (wcnt == '0)) begin
      mem_re   = ~lat.err & (lat.op == OP_RD);
    end
  end

  // Write commits on the edge ending RESP unless reset aborts it.
  always_comb begin
    mem_we   = reset & (state == RESP) & (lat.op == OP_WR) & ~lat.err;
    mem_widx = IDX_W'(word_index(lat.addr, ADDR_BASE));
  end

  // Access FSM with wait counter and registered completion pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      wcnt        <= '0;
      lat         <= '0;
      rdata_valid <= 1'b0;
      resp_ack    <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      resp_ack    <= 1'b0;
      addr_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            lat <= in_req;
            if (ZERO_WAIT) begin
              state       <= RESP;
              resp_ack    <= 1'b1;
              addr_err    <= in_req.err;
              rdata_valid <= ~in_req.err & (in_req.op == OP_RD);
            end else begin
              state <= BUSY;
              wcnt  <= WCNT_INIT;
            end
          end
        end
        BUSY: begin
          if (wcnt == '0) begin
            state       <= RESP;
            resp_ack    <= 1'b1;
            addr_err    <= lat.err;
            rdata_valid <= ~lat.err & (lat.op == OP_RD);
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .widx  (mem_widx),
    .wdata (lat.wdata),
    .re    (mem_re),
    .ridx  (mem_ridx),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) against a word-array model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Index 0: WAIT_CYCLES=2, index 1: WAIT_CYCLES=0.
  logic        rd_en [2];
  logic        wr_en [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        rvalid[2];
  logic        ack   [2];
  logic        aerr  [2];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .ADDR_BASE(BASE)) dut_w2 (
    .clk(clk), .reset(reset), .req_read_en(rd_en[0]), .req_write_en(wr_en[0]),
    .req_addr(addr[0]), .req_wdata(wdata[0]), .stall(stall[0]), .rdata(rdata[0]),
    .rdata_valid(rvalid[0]), .resp_ack(ack[0]), .addr_err(aerr[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_BASE(BASE)) dut_w0 (
    .clk(clk), .reset(reset), .req_read_en(rd_en[1]), .req_write_en(wr_en[1]),
    .req_addr(addr[1]), .req_wdata(wdata[1]), .stall(stall[1]), .rdata(rdata[1]),
    .rdata_valid(rvalid[1]), .resp_ack(ack[1]), .addr_err(aerr[1]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: storage image, which words are defined, and the expected rdata register.
  logic [31:0] mem_m  [2][DEPTH];
  bit          known  [2][DEPTH];
  logic [31:0] exp_rd [2];
  bit          exp_known[2];

  typedef struct packed {
    int          stall_cyc;
    int          ack_cyc;
    bit          err;
    bit          rv;
    bit          hold_ok;
    bit          stall_at_ack;
    logic [31:0] rd;
    logic [31:0] rd_start;
  } obs_t;

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit m_err(input logic [31:0] a, input bit rd, input bit wr);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || ((off >> 2) >= DEPTH) || (rd && wr);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  task automatic m_apply(input int d, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] wd);
    if (!m_err(a, rd, wr)) begin
      int i;
      i = m_idx(a);
      if (wr) begin
        mem_m[d][i] = wd;
        known[d][i] = 1'b1;
      end else begin
        exp_rd[d]    = mem_m[d][i];
        exp_known[d] = known[d][i];
      end
    end
  endtask

  // Presents one request, records what the DUT does until resp_ack (bounded), then drops it.
  task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit wig, input logic [31:0] wig_a,
                        output obs_t o);
    o = '0;
    o.ack_cyc = -1;
    o.hold_ok = 1'b1;
    rd_en[d] = rd; wr_en[d] = wr; addr[d] = a; wdata[d] = wd;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) o.rd_start = rdata[d];
      if (ack[d] === 1'b1) begin
        o.ack_cyc      = k;
        o.err          = aerr[d];
        o.rv           = rvalid[d];
        o.rd           = rdata[d];
        o.stall_at_ack = stall[d];
      end else begin
        if (stall[d] === 1'b1) o.stall_cyc++;
        if (rdata[d] !== o.rd_start) o.hold_ok = 1'b0;
        if (rvalid[d] !== 1'b0 || aerr[d] !== 1'b0) o.hold_ok = 1'b0;
      end
      @(posedge clk); #1;
      if (wig && k == 0) begin
        addr[d]  = wig_a;
        wdata[d] = ~wd;
      end
      if (o.ack_cyc >= 0) break;
    end
    rd_en[d] = 1'b0; wr_en[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd_en[d] = 1'b1; wr_en[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (stall[d] !== 1'b0 || rdata[d] !== 32'h0 || ack[d] !== 1'b0 ||
            rvalid[d] !== 1'b0 || aerr[d] !== 1'b0) begin
          errors++;
          $display("FAIL reset_hold dut%0d: stall=%b rdata=%h ack=%b rv=%b err=%b, want all 0",
                   d, stall[d], rdata[d], ack[d], rvalid[d], aerr[d]);
        end
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    rd_en[0] = 1'b0; rd_en[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (stall[d] !== 1'b0) begin
          errors++;
          $display("FAIL reset_release_stall dut%0d: got %b want 0", d, stall[d]);
        end
      end
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      exp_rd[d] = 32'h0; exp_known[d] = 1'b1;
    end
  endtask

  task automatic test_write_read();
    obs_t o;
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, o);
    m_apply(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if (o.stall_cyc !== 3 || o.ack_cyc !== 3 || o.err !== 1'b0 || o.rv !== 1'b0) begin
      errors++;
      $display("FAIL wr_10 timing: stall_cyc=%0d ack_cyc=%0d err=%b rv=%b want 3 3 0 0",
               o.stall_cyc, o.ack_cyc, o.err, o.rv);
    end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, o);
    m_apply(0, 1'b1, 1'b0, 32'h10, 32'h0);
    checks++;
    if (o.ack_cyc !== 3 || o.rv !== 1'b1 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL rd_10 timing: ack_cyc=%0d rv=%b err=%b want 3 1 0", o.ack_cyc, o.rv, o.err);
    end
    checks++;
    if (o.rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_10 data: got %h want %h", o.rd, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_zero_wait();
    obs_t o;
    int   t0;
    access(1, 1'b0, 1'b1, 32'h0, 32'h600D_F00D, 1'b0, 32'h0, o);
    m_apply(1, 1'b0, 1'b1, 32'h0, 32'h600D_F00D);
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, o);
    m_apply(1, 1'b1, 1'b0, 32'h0, 32'h0);
    checks++;
    if (o.stall_cyc !== 1 || o.ack_cyc !== 1 || o.rv !== 1'b1 || o.rd !== 32'h600D_F00D) begin
      errors++;
      $display("FAIL zw_rd0: stall_cyc=%0d ack_cyc=%0d rv=%b rd=%h want 1 1 1 600df00d",
               o.stall_cyc, o.ack_cyc, o.rv, o.rd);
    end
    t0 = cyc;
    for (int i = 0; i < 4; i++) access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, o);
    checks++;
    if (cyc - t0 !== 8) begin
      errors++;
      $display("FAIL zw_back_to_back cycles: got %0d want 8", cyc - t0);
    end
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      access(0, 1'b0, 1'b1, 32'(4 * (i + 1)), 32'hB2B0_0000 + 32'(i), 1'b0, 32'h0, o);
      m_apply(0, 1'b0, 1'b1, 32'(4 * (i + 1)), 32'hB2B0_0000 + 32'(i));
    end
    checks++;
    if (cyc - t0 !== 12) begin
      errors++;
      $display("FAIL w2_back_to_back cycles: got %0d want 12", cyc - t0);
    end
  endtask

  task automatic test_errors();
    obs_t o;
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0, o);
    checks++;
    if (o.ack_cyc !== 3 || o.err !== 1'b1 || o.rv !== 1'b0 || o.rd !== exp_rd[0]) begin
      errors++;
      $display("FAIL err_misaligned: ack_cyc=%0d err=%b rv=%b rd=%h want 3 1 0 %h",
               o.ack_cyc, o.err, o.rv, o.rd, exp_rd[0]);
    end
    access(0, 1'b0, 1'b1, 32'h0, 32'h0BAD_CAFE, 1'b0, 32'h0, o);
    m_apply(0, 1'b0, 1'b1, 32'h0, 32'h0BAD_CAFE);
    access(0, 1'b0, 1'b1, 32'(4 * DEPTH), 32'hFFFF_FFFF, 1'b0, 32'h0, o);
    checks++;
    if (o.ack_cyc !== 3 || o.err !== 1'b1) begin
      errors++;
      $display("FAIL err_range_wr: ack_cyc=%0d err=%b want 3 1", o.ack_cyc, o.err);
    end
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, o);
    m_apply(0, 1'b1, 1'b0, 32'h0, 32'h0);
    checks++;
    if (o.err !== 1'b0 || o.rv !== 1'b1 || o.rd !== 32'h0BAD_CAFE) begin
      errors++;
      $display("FAIL err_range_after_rd0: err=%b rv=%b rd=%h want 0 1 0badcafe", o.err, o.rv, o.rd);
    end
    for (int d = 0; d < 2; d++) begin
      access(d, 1'b1, 1'b1, 32'h8, 32'h5555_AAAA, 1'b0, 32'h0, o);
      checks++;
      if (o.ack_cyc !== wait_of(d) + 1 || o.err !== 1'b1 || o.rv !== 1'b0) begin
        errors++;
        $display("FAIL err_both_en dut%0d: ack_cyc=%0d err=%b rv=%b want %0d 1 0",
                 d, o.ack_cyc, o.err, o.rv, wait_of(d) + 1);
      end
    end
    access(1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, o);
    checks++;
    if (o.err !== 1'b1 || o.rv !== 1'b0 || o.rd !== exp_rd[1]) begin
      errors++;
      $display("FAIL err_wrap_addr: err=%b rv=%b rd=%h want 1 0 %h", o.err, o.rv, o.rd, exp_rd[1]);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    access(0, 1'b0, 1'b1, 32'h20, 32'hCAFE_0020, 1'b0, 32'h0, o);
    m_apply(0, 1'b0, 1'b1, 32'h20, 32'hCAFE_0020);
    rd_en[0] = 1'b0; wr_en[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (stall[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_req_stall: got %b want 1", stall[0]);
    end
    @(posedge clk); #1;
    reset = 1'b0; wr_en[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      exp_rd[d] = 32'h0; exp_known[d] = 1'b1;
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (stall[0] !== 1'b0 || ack[0] !== 1'b0 || rdata[0] !== 32'h0) begin
        errors++;
        $display("FAIL mid_reset_idle: stall=%b ack=%b rdata=%h want 0 0 0", stall[0], ack[0], rdata[0]);
      end
    end
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, o);
    m_apply(0, 1'b1, 1'b0, 32'h20, 32'h0);
    checks++;
    if (o.rv !== 1'b1 || o.rd !== 32'hCAFE_0020) begin
      errors++;
      $display("FAIL mid_reset_aborted_wr: rv=%b rd=%h want 1 cafe0020", o.rv, o.rd);
    end
  endtask

  task automatic test_stability();
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      access(d, 1'b0, 1'b1, 32'h30, 32'h3030_0000 + 32'(d), 1'b0, 32'h0, o);
      m_apply(d, 1'b0, 1'b1, 32'h30, 32'h3030_0000 + 32'(d));
      access(d, 1'b0, 1'b1, 32'h34, 32'h3434_0000 + 32'(d), 1'b0, 32'h0, o);
      m_apply(d, 1'b0, 1'b1, 32'h34, 32'h3434_0000 + 32'(d));
      access(d, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 32'h34, o);
      m_apply(d, 1'b1, 1'b0, 32'h30, 32'h0);
      checks++;
      if (o.rd !== 32'h3030_0000 + 32'(d)) begin
        errors++;
        $display("FAIL stable_rd dut%0d: got %h want %h", d, o.rd, 32'h3030_0000 + 32'(d));
      end
      access(d, 1'b0, 1'b1, 32'h38, 32'h3838_0000 + 32'(d), 1'b1, 32'h3C, o);
      m_apply(d, 1'b0, 1'b1, 32'h38, 32'h3838_0000 + 32'(d));
      access(d, 1'b1, 1'b0, 32'h38, 32'h0, 1'b0, 32'h0, o);
      m_apply(d, 1'b1, 1'b0, 32'h38, 32'h0);
      checks++;
      if (o.rd !== 32'h3838_0000 + 32'(d)) begin
        errors++;
        $display("FAIL stable_wr dut%0d: got %h want %h", d, o.rd, 32'h3838_0000 + 32'(d));
      end
    end
  endtask

  task automatic test_random();
    obs_t        o;
    int          r, w;
    bit          rd, wr, wig, e;
    logic [31:0] a, wd, wa, pre;
    bit          pre_known;
    for (int d = 0; d < 2; d++) begin
      w = wait_of(d);
      for (int n = 0; n < 60; n++) begin
        r  = int'($urandom_range(0, 19));
        rd = (r < 10) || (r == 19);
        wr = (r >= 10);
        a  = $urandom_range(0, DEPTH + 1) << 2;
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        wd  = $urandom;
        wig = 1'($urandom_range(0, 1));
        wa  = $urandom;
        pre = exp_rd[d];
        pre_known = exp_known[d];
        access(d, rd, wr, a, wd, wig, wa, o);
        e = m_err(a, rd, wr);
        m_apply(d, rd, wr, a, wd);
        checks++;
        if (o.stall_cyc !== w + 1 || o.ack_cyc !== w + 1 || o.stall_at_ack !== 1'b0 ||
            o.hold_ok !== 1'b1) begin
          errors++;
          $display("FAIL rnd_timing dut%0d #%0d: stall_cyc=%0d ack_cyc=%0d stall@ack=%b hold=%b want %0d %0d 0 1",
                   d, n, o.stall_cyc, o.ack_cyc, o.stall_at_ack, o.hold_ok, w + 1, w + 1);
        end
        checks++;
        if (o.err !== e || o.rv !== (!e && !wr)) begin
          errors++;
          $display("FAIL rnd_status dut%0d #%0d a=%h rd=%b wr=%b: err=%b rv=%b want %b %b",
                   d, n, a, rd, wr, o.err, o.rv, e, (!e && !wr));
        end
        if (pre_known) begin
          checks++;
          if (o.rd_start !== pre) begin
            errors++;
            $display("FAIL rnd_rdata_hold dut%0d #%0d: got %h want %h", d, n, o.rd_start, pre);
          end
        end
        if (exp_known[d]) begin
          checks++;
          if (o.rd !== exp_rd[d]) begin
            errors++;
            $display("FAIL rnd_rdata dut%0d #%0d a=%h: got %h want %h", d, n, a, o.rd, exp_rd[d]);
          end
        end
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_en[d] = 1'b0; wr_en[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
      exp_rd[d] = 32'h0; exp_known[d] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_zero_wait();
    test_errors();
    test_reset_mid();
    test_stability();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
